uart_rx_ext: RTL and testbench

UART_RX_EXT -- requirements
Module: uart_rx_ext

---
 rtl/uart_rx_ext.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// UART receiver with 3-sample majority voting, optional parity, 1 or 2 stop bits,
// break detection and a small receive FIFO carrying per-entry parity/framing flags.
module uart_rx_ext #(
  parameter int unsigned CLK_DIV    = 5208,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int unsigned CntW  = $clog2(CLK_DIV);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW  = DATA_BITS + 2;

  localparam logic [CntW-1:0] CntMax   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] SampA    = CntW'(CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] SampB    = CntW'(CLK_DIV / 2);
  localparam logic [CntW-1:0] Resolve  = CntW'(CLK_DIV / 2 + 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);
  localparam logic            ParEn    = (PARITY_EN != 0);
  localparam logic            ParOdd   = (PARITY_ODD != 0);
  localparam logic            TwoStop  = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } state_e;

  logic [1:0]           sync_q;
  logic                 line, line_prev_q;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           samp_q, samp_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 push_q, push_d;
  logic                 break_q, break_d;

  logic                 wrap, resolve, bit_val, last_stop;

  logic [AddrW:0]       wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]       rd_ptr_q, rd_ptr_d;
  logic [EntW-1:0]      mem_q [FIFO_DEPTH];
  logic [EntW-1:0]      head;
  logic                 full, pop, push_acc;

  assign line      = sync_q[1];
  assign wrap      = (cnt_q == CntMax);
  assign resolve   = (cnt_q == Resolve);
  assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);
  assign last_stop = !TwoStop || stop_idx_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    samp_d     = samp_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    par_bit_d  = par_bit_q;
    stop_idx_d = stop_idx_q;
    push_d     = 1'b0;
    break_d    = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    if (cnt_q == SampA) samp_d[0] = line;
    if (cnt_q == SampB) samp_d[1] = line;

    unique case (state_q)
      StIdle: begin
        if (line_prev_q && !line) begin
          state_d    = StStart;
          bit_idx_d  = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          par_bit_d  = 1'b0;
          stop_idx_d = 1'b0;
        end
      end
      StStart: begin
        if (resolve && bit_val) begin
          state_d = StIdle;
        end else if (wrap) begin
          state_d = StData;
        end
      end
      StData: begin
        if (resolve) shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_idx_q == LastBit) begin
            state_d = ParEn ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (resolve) begin
          par_bit_d = bit_val;
          perr_d    = bit_val != ((^shreg_q) ^ ParOdd);
        end
        if (wrap) state_d = StStop;
      end
      StStop: begin
        if (resolve) begin
          if (!bit_val) ferr_d = 1'b1;
          // The last stop bit ends the frame at mid-bit so back-to-back frames are not missed.
          if (last_stop) begin
            if ((shreg_q == '0) && (!ParEn || !par_bit_q) && !bit_val) begin
              break_d = 1'b1;
              state_d = StBrkWait;
            end else begin
              push_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        if (wrap && !last_stop) stop_idx_d = 1'b1;
      end
      StBrkWait: begin
        if (line) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) cnt_d = '0;
  end

  assign pop      = rx_valid && rx_ready;
  assign full     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign push_acc = push_q && (!full || pop);
  assign wr_ptr_d = wr_ptr_q + (AddrW+1)'(push_acc);
  assign rd_ptr_d = rd_ptr_q + (AddrW+1)'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      line_prev_q <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      samp_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      par_bit_q   <= 1'b0;
      stop_idx_q  <= 1'b0;
      push_q      <= 1'b0;
      break_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      sync_q      <= {sync_q[0], rs232};
      line_prev_q <= line;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      samp_q      <= samp_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      par_bit_q   <= par_bit_d;
      stop_idx_q  <= stop_idx_d;
      push_q      <= push_d;
      break_q     <= break_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage is not reset; the outputs are gated by rx_valid instead.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= {shreg_q, perr_q, ferr_q};
    end
  end

  assign head      = mem_q[rd_ptr_q[AddrW-1:0]];
  assign rx_valid  = (wr_ptr_q != rd_ptr_q);
  assign rx_data   = rx_valid ? head[EntW-1:2] : '0;
  assign rx_perr   = rx_valid && head[1];
  assign rx_ferr   = rx_valid && head[0];
  assign overrun   = push_q && full && !pop;
  assign break_det = break_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed and random checks of uart_rx_ext over four parameter sets, against a
// frame-level model (data, parity rule, stop bits, break rule).
module tb_uart_rx_ext;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ser = 4'hF;
  logic [3:0] rdy = 4'h0;

  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [3:0] pe, fe, vl, ov, bd, bz;

  int nchk = 0;
  int nfail = 0;

  // Monitor state (written only by the monitor process)
  logic [10:0] got0 [256];
  logic [10:0] got1 [256];
  logic [10:0] got2 [256];
  logic [10:0] got3 [256];
  int gn0 = 0, gn1 = 0, gn2 = 0, gn3 = 0;
  int vcnt0 = 0, ovcnt2 = 0, brk0 = 0, brk1 = 0;

  always #5 clk = ~clk;

  uart_rx_ext #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .rs232(ser[0]), .rx_data(d0), .rx_perr(pe[0]), .rx_ferr(fe[0]),
    .rx_valid(vl[0]), .rx_ready(rdy[0]), .overrun(ov[0]), .break_det(bd[0]), .busy(bz[0]));

  uart_rx_ext #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .rs232(ser[1]), .rx_data(d1), .rx_perr(pe[1]), .rx_ferr(fe[1]),
    .rx_valid(vl[1]), .rx_ready(rdy[1]), .overrun(ov[1]), .break_det(bd[1]), .busy(bz[1]));

  uart_rx_ext #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                .STOP_BITS(1), .FIFO_DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .rs232(ser[2]), .rx_data(d2), .rx_perr(pe[2]), .rx_ferr(fe[2]),
    .rx_valid(vl[2]), .rx_ready(rdy[2]), .overrun(ov[2]), .break_det(bd[2]), .busy(bz[2]));

  uart_rx_ext #(.CLK_DIV(16), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0),
                .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .rs232(ser[3]), .rx_data(d3), .rx_perr(pe[3]), .rx_ferr(fe[3]),
    .rx_valid(vl[3]), .rx_ready(rdy[3]), .overrun(ov[3]), .break_det(bd[3]), .busy(bz[3]));

  always @(negedge clk) begin
    if (vl[0] && rdy[0]) begin got0[gn0[7:0]] <= {1'b0, d0, pe[0], fe[0]}; gn0 <= gn0 + 1; end
    if (vl[1] && rdy[1]) begin got1[gn1[7:0]] <= {1'b0, d1, pe[1], fe[1]}; gn1 <= gn1 + 1; end
    if (vl[2] && rdy[2]) begin got2[gn2[7:0]] <= {1'b0, d2, pe[2], fe[2]}; gn2 <= gn2 + 1; end
    if (vl[3] && rdy[3]) begin got3[gn3[7:0]] <= {2'b0, d3, pe[3], fe[3]}; gn3 <= gn3 + 1; end
    vcnt0  <= vcnt0 + int'(vl[0]);
    ovcnt2 <= ovcnt2 + int'(ov[2]);
    brk0   <= brk0 + int'(bd[0]);
    brk1   <= brk1 + int'(bd[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] ent(input logic [8:0] d, input logic p, input logic f);
    return {d, p, f};
  endfunction

  // Transmit start, data (LSB first), optional parity, stop bit(s), then idle high.
  task automatic send_frame(input int idx, input logic [8:0] data, input int nd, input bit pen,
                            input logic pb, input int ns, input logic s1, input logic s2);
    logic [15:0] bits;
    int n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nd; i++) begin bits[n] = data[i]; n++; end
    if (pen) begin bits[n] = pb; n++; end
    bits[n] = s1; n++;
    if (ns == 2) begin bits[n] = s2; n++; end
    for (int i = 0; i < n; i++) begin
      ser[idx] = bits[i];
      repeat (BIT) tick();
    end
    ser[idx] = 1'b1;
    repeat (2 * BIT) tick();
  endtask

  initial begin
    int base, gb, bc;
    logic [10:0] exp_e [32];
    int nexp, brk_exp;
    logic [7:0] rd;
    logic rpb, rst_bit;

    // Reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_outputs", {vl[0], bz[0], ov[0], bd[0], pe[0], fe[0], d0}, 32'h0);
    check("reset_outputs_u2", {vl[2], bz[2], ov[2], d2}, 32'h0);

    // 1: 8N1 0xA5 with ready high
    rdy = 4'hF;
    base = vcnt0; gb = gn0;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    check("s1_valid_cycles", vcnt0 - base, 1);
    check("s1_pops", gn0 - gb, 1);
    check("s1_entry", got0[gb], ent(9'h0A5, 1'b0, 1'b0));

    // 2: even parity, 0x03 has even weight so parity bit 1 is an error
    gb = gn1;
    send_frame(1, 9'h003, 8, 1, 1'b1, 1, 1'b1, 1'b1);
    send_frame(1, 9'h003, 8, 1, 1'b0, 1, 1'b1, 1'b1);
    check("s2_pops", gn1 - gb, 2);
    check("s2_bad_parity", got1[gb], ent(9'h003, 1'b1, 1'b0));
    check("s2_good_parity", got1[gb+1], ent(9'h003, 1'b0, 1'b0));

    // 3: framing error then clean frame
    gb = gn0;
    send_frame(0, 9'h07E, 8, 0, 1'b0, 1, 1'b0, 1'b1);
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    check("s3_pops", gn0 - gb, 2);
    check("s3_ferr", got0[gb], ent(9'h07E, 1'b0, 1'b1));
    check("s3_clean", got0[gb+1], ent(9'h011, 1'b0, 1'b0));

    // 4: 3-cycle glitch; START spans counts 0..M+1 before the false start is rejected
    base = vcnt0; bc = 0;
    ser[0] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 3) ser[0] = 1'b1;
      tick();
      bc += int'(bz[0]);
    end
    check("s4_busy_cycles", bc, 10);
    check("s4_no_valid", vcnt0 - base, 0);
    check("s4_idle", bz[0], 1'b0);

    // 5: overrun on a 2-deep FIFO
    rdy[2] = 1'b0;
    base = ovcnt2; gb = gn2;
    send_frame(2, 9'h001, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(2, 9'h002, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(2, 9'h003, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    check("s5_overrun_pulses", ovcnt2 - base, 1);
    check("s5_head_held", {vl[2], d2}, {1'b1, 8'h01});
    rdy[2] = 1'b1;
    repeat (5) tick();
    check("s5_pops", gn2 - gb, 2);
    check("s5_pop0", got2[gb], ent(9'h001, 1'b0, 1'b0));
    check("s5_pop1", got2[gb+1], ent(9'h002, 1'b0, 1'b0));
    check("s5_empty", vl[2], 1'b0);

    // 6: break
    base = brk0; gb = gn0; bc = vcnt0;
    ser[0] = 1'b0;
    repeat (30 * BIT) tick();
    check("s6_busy_low_line", bz[0], 1'b1);
    check("s6_break_pulses", brk0 - base, 1);
    ser[0] = 1'b1;
    repeat (6) tick();
    check("s6_busy_released", bz[0], 1'b0);
    check("s6_no_push", vcnt0 - bc, 0);

    // 7: 7 data bits, 2 stop bits, second stop bit low
    gb = gn3;
    send_frame(3, 9'h05A, 7, 0, 1'b0, 2, 1'b1, 1'b0);
    send_frame(3, 9'h02B, 7, 0, 1'b0, 2, 1'b1, 1'b1);
    check("s7_pops", gn3 - gb, 2);
    check("s7_ferr", got3[gb], ent(9'h05A, 1'b0, 1'b1));
    check("s7_clean", got3[gb+1], ent(9'h02B, 1'b0, 1'b0));

    // 8: reset in DATA with an entry already buffered
    rdy[0] = 1'b0;
    gb = gn0;
    send_frame(0, 9'h042, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    check("s8_buffered", {vl[0], d0}, {1'b1, 8'h42});
    ser[0] = 1'b0;
    repeat (BIT) tick();
    ser[0] = 1'b1;
    repeat (BIT + 8) tick();
    check("s8_busy_in_data", bz[0], 1'b1);
    rst = 1'b1;
    tick();
    check("s8_reset_outputs", {vl[0], bz[0], ov[0], bd[0], pe[0], fe[0], d0}, 32'h0);
    rst = 1'b0;
    rdy[0] = 1'b1;
    repeat (2 * BIT) tick();
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    check("s8_pops", gn0 - gb, 1);
    check("s8_after_reset", got0[gb], ent(9'h03C, 1'b0, 1'b0));

    // Random frames on the even-parity receiver
    gb = gn1; base = brk1; nexp = 0; brk_exp = 0;
    for (int k = 0; k < 12; k++) begin
      rd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rd = 8'h00;
      rpb = 1'($urandom_range(0, 1));
      rst_bit = ($urandom_range(0, 2) != 0);
      send_frame(1, {1'b0, rd}, 8, 1, rpb, 1, rst_bit, 1'b1);
      if (rd == 8'h00 && !rpb && !rst_bit) begin
        brk_exp++;
      end else begin
        exp_e[nexp] = ent({1'b0, rd}, rpb != 1'($countones(rd) % 2), !rst_bit);
        nexp++;
      end
    end
    check("rnd_pops", gn1 - gb, nexp);
    check("rnd_breaks", brk1 - base, brk_exp);
    for (int k = 0; k < nexp; k++) begin
      check($sformatf("rnd_entry%0d", k), got1[gb+k], exp_e[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
